// File: rtl/video_stream_packetizer.sv
// Purpose: turns the camera pixel strobe (pixel + frame-start, no stall) into SOP/EOP-framed ready/valid beats.
// Latency: a pixel accepted at edge N is presented on data_out after edge N when the FIFO was empty.
// Backpressure: a show-ahead FIFO absorbs ready_in stalls; on overflow the frame is cut and closed with an EOP terminator.
//
// Ports:
//   clk, reset                    - single clock, asynchronous active-high reset
//   pixel_in/pixel_valid_in       - RGB444 pixel and its strobe (source cannot stall)
//   frame_start_in                - marks the first pixel of a frame (qualified by pixel_valid_in)
//   ready_in/valid_out            - downstream handshake; beat = data_out + startofpacket_out/endofpacket_out
//   frame_dropped_out             - one-cycle pulse when the current frame is truncated
//   fifo_level_out                - registered FIFO occupancy
module video_stream_packetizer #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [11:0]                   pixel_in,
  input  logic                          pixel_valid_in,
  input  logic                          frame_start_in,
  input  logic                          ready_in,
  output logic                          valid_out,
  output logic [11:0]                   data_out,
  output logic                          startofpacket_out,
  output logic                          endofpacket_out,
  output logic                          frame_dropped_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST     = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST     = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [LVL_W-1:0] LVL_FULL     = LVL_W'(FIFO_DEPTH);
  localparam logic             SINGLE_PIXEL = (IMG_WIDTH * IMG_HEIGHT == 1);

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [11:0] pix;
  } entry_t;

  typedef enum logic [1:0] {W_IDLE, W_CAPTURE, W_TERM, W_DROP} wstate_t;

  // ---------------- FIFO ----------------
  entry_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level;
  entry_t           head;
  entry_t           wr_entry;
  logic             wr_en, pop, wr_ok;

  assign head      = mem[rd_ptr];
  assign valid_out = (level != '0);
  assign pop       = valid_out && ready_in;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign wr_ok     = (level != LVL_FULL) || pop;

  // Gate the head with valid so stale RAM contents never reach the outputs.
  assign data_out          = valid_out ? head.pix : 12'h000;
  assign startofpacket_out = valid_out && head.sop;
  assign endofpacket_out   = valid_out && head.eop;
  assign fifo_level_out    = level;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // ---------------- write FSM ----------------
  wstate_t          state, state_n;
  logic [COL_W-1:0] col, col_n;
  logic [ROW_W-1:0] row, row_n;
  logic             sop_written, sop_written_n;
  logic             term_to_idle, term_to_idle_n;  // terminator was caused by an early frame start
  logic             drop_n;
  logic             frame_last;

  assign frame_last = (col == COL_LAST) && (row == ROW_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= W_IDLE;
      col               <= '0;
      row               <= '0;
      sop_written       <= 1'b0;
      term_to_idle      <= 1'b0;
      frame_dropped_out <= 1'b0;
    end else begin
      state             <= state_n;
      col               <= col_n;
      row               <= row_n;
      sop_written       <= sop_written_n;
      term_to_idle      <= term_to_idle_n;
      frame_dropped_out <= drop_n;
    end
  end

  always_comb begin
    state_n        = state;
    col_n          = col;
    row_n          = row;
    sop_written_n  = sop_written;
    term_to_idle_n = term_to_idle;
    drop_n         = 1'b0;
    wr_en          = 1'b0;
    wr_entry.sop   = 1'b0;
    wr_entry.eop   = 1'b0;
    wr_entry.pix   = pixel_in;

    case (state)
      // W_DROP resumes exactly like W_IDLE once a frame start shows up.
      W_IDLE, W_DROP: begin
        if (pixel_valid_in && frame_start_in) begin
          if (wr_ok) begin
            wr_en         = 1'b1;
            wr_entry.sop  = 1'b1;
            wr_entry.eop  = SINGLE_PIXEL;
            sop_written_n = !SINGLE_PIXEL;
            // Position after pixel (0,0); a one-column image wraps straight to row 1.
            if (COL_LAST == '0) begin
              col_n = '0;
              row_n = ROW_W'(1);
            end else begin
              col_n = COL_W'(1);
              row_n = '0;
            end
            state_n = SINGLE_PIXEL ? W_IDLE : W_CAPTURE;
          end else begin
            // Nothing was written for this frame, so no terminator is owed.
            drop_n  = 1'b1;
            state_n = W_DROP;
          end
        end
      end

      W_CAPTURE: begin
        if (pixel_valid_in) begin
          if (frame_start_in) begin
            drop_n         = 1'b1;
            term_to_idle_n = 1'b1;
            state_n        = W_TERM;
          end else if (!wr_ok) begin
            drop_n         = 1'b1;
            term_to_idle_n = 1'b0;
            state_n        = W_TERM;
          end else begin
            wr_en        = 1'b1;
            wr_entry.sop = !sop_written;
            wr_entry.eop = frame_last;
            if (frame_last) begin
              col_n         = '0;
              row_n         = '0;
              sop_written_n = 1'b0;
              state_n       = W_IDLE;
            end else if (col == COL_LAST) begin
              col_n = '0;
              row_n = row + 1'b1;
            end else begin
              col_n = col + 1'b1;
            end
          end
        end
      end

      W_TERM: begin
        if (wr_ok) begin
          wr_en         = 1'b1;
          wr_entry.sop  = 1'b0;
          wr_entry.eop  = 1'b1;
          wr_entry.pix  = 12'h000;
          col_n         = '0;
          row_n         = '0;
          sop_written_n = 1'b0;
          state_n       = term_to_idle ? W_IDLE : W_DROP;
        end
      end

      default: state_n = W_IDLE;
    endcase
  end

endmodule

// File: doc/video_stream_packetizer.md
# video_stream_packetizer

Upstream stage of the video filter chain. Converts the raw camera-capture pixel stream (pixel strobe plus frame-start pulse, no back-pressure) into a ready/valid packet stream with start/end-of-packet framing, which is consumed by the edge filter. A small FIFO absorbs downstream stalls. Every packet the block emits is terminated with an end-of-packet beat, including packets from frames that are lost to overflow or to a short frame.

## Interface
- IMG_WIDTH, 320, pixels per line
- IMG_HEIGHT, 240, lines per frame
- FIFO_DEPTH, 16, entries; power of two, ≥ 4
- clk  in  1  single system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- pixel_in  in  12  RGB444 pixel {R[11:8], G[7:4], B[3:0]}
- pixel_valid_in  in  1  pixel_in valid this cycle; source cannot stall
- frame_start_in  in  1  high with the first pixel of a frame (qualified by pixel_valid_in)
- ready_in  in  1  downstream accepts a beat this cycle
- valid_out  out  1  beat available
- data_out  out  12  beat pixel
- startofpacket_out  out  1  first beat of packet
- endofpacket_out  out  1  last beat of packet
- frame_dropped_out  out  1  one-cycle pulse: the current frame was truncated
- fifo_level_out  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- **FIFO:** entries are 14 bits {sop, eop, pixel}. The read side is show-ahead: the head entry drives data_out, startofpacket_out and endofpacket_out.
  - valid_out = level ≠ 0.
  - Pop when valid_out && ready_in.
  - A write is allowed when not full, or when full with a pop in the same cycle.
- **Write FSM** uses counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1), and flag sop_written.
- **W_IDLE**
  - Accepted pixel (pixel_valid_in) without frame_start_in is discarded.
  - Accepted pixel with frame_start_in: write it with sop=1, set col=1 and row=0, set sop_written, go to W_CAPTURE.
  - If the FIFO is full (no pop) on that first pixel: discard it, pulse frame_dropped_out, go to W_DROP. No terminator is written because no packet was started.
- **W_CAPTURE**, on each accepted pixel:
  - Normal case: write with sop=0 and eop=(col==IMG_WIDTH-1 && row==IMG_HEIGHT-1), then advance col/row.
  - On eop written: go to W_IDLE.
  - Overflow (write not allowed): discard the pixel, pulse frame_dropped_out, go to W_TERM.
  - Early frame_start_in (short frame): discard the pixel, pulse frame_dropped_out, go to W_TERM.
- **W_TERM**
  - When a write is allowed, write the terminator {sop=0, eop=1, pixel=12'h000}.
  - Next state: W_IDLE if the termination was caused by an early frame_start, else W_DROP.
  - Incoming pixels in W_TERM are discarded.
- **W_DROP**
  - Discard pixels until a pixel with frame_start_in arrives.
  - Then proceed exactly as in W_IDLE with that pixel.
- **Single-pixel frame:** if IMG_WIDTH*IMG_HEIGHT==1, the first pixel carries sop=1 and eop=1, and the FSM returns to W_IDLE.
- **Reset:**
  - Clears pointers, level, counters and sop_written.
  - FSM goes to W_IDLE.
  - All outputs 0.

## Timing
- Reset values: valid_out=0, data_out=0, startofpacket_out=0, endofpacket_out=0, frame_dropped_out=0, fifo_level_out=0. Reset takes effect immediately (asynchronous).
- Latency into an empty FIFO: a pixel accepted at edge N drives valid_out and data_out after edge N.
- Throughput: 1 beat/cycle in and out.
- fifo_level_out is registered. It updates on the edge of each write/pop: +1 on write only, −1 on pop only, unchanged on both.
- frame_dropped_out is registered. It is high for exactly the one cycle following the edge at which the loss was detected.
- The terminator is written no earlier than the cycle after the loss, and only once a slot exists.
- Outputs hold stable while valid_out && !ready_in.

## Test plan
- **Clean frame:** IMG_WIDTH=4, IMG_HEIGHT=2, ready_in=1, reset, then 8 consecutive pixels 0x001..0x008 with frame_start on the first.
  - Expect 8 beats, each one cycle after its input.
  - sop only on 0x001, eop only on 0x008.
  - frame_dropped_out stays 0.
- **Overflow:** FIFO_DEPTH=16, IMG_WIDTH=8, IMG_HEIGHT=4, ready_in=0, then 20 pixels.
  - After 16 writes, fifo_level_out=16.
  - Pixel 17 is dropped, with a frame_dropped_out pulse.
  - Raise ready_in: expect 16 beats, then one terminator beat 0x000 with eop.
  - Later pixels are ignored until the next frame_start.
- **Full with simultaneous pop:** level=16, ready_in=1, continuous input.
  - No drop, level stays 16, output sequence contiguous.
- **Short frame:** frame_start again after 5 of 8 pixels.
  - The 5 pixels are followed by terminator 0x000 with eop, and frame_dropped_out pulses.
  - The next frame_start begins a new packet with sop.
- **No frame start:** pixels with no frame_start after reset.
  - valid_out stays 0 and fifo_level_out stays 0.
- **Mid-frame reset:** assert reset mid-frame with a non-empty FIFO.
  - All outputs 0 in the same cycle.
  - The next frame starts cleanly with sop.
